// File: rtl/conv_stream_engine_if.sv
// Output pixel stream of the convolution engine.
// Handshake: a pixel transfers on a rising clk edge where out_valid && out_ready.
// Once out_valid rises, out_data/out_row/out_col hold steady and out_valid stays
// high until that transfer; out_ready may change freely and never gates out_valid.
interface conv_stream_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int COORD_W    = 3
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [COORD_W-1:0]    out_row;
   logic [COORD_W-1:0]    out_col;

   modport master (output out_valid, output out_data, output out_row, output out_col,
                   input out_ready);
   modport slave  (input out_valid, input out_data, input out_row, input out_col,
                   output out_ready);
endinterface

// File: rtl/conv_stream_engine.sv
// Multi-channel 2-D convolution engine. For each output pixel it accumulates one
// input channel per cycle on top of the bias, then shifts, clamps (ReLU or signed
// saturation) and presents the pixel on a valid/ready stream in raster order.
// ifmap, weights and bias are read live and must stay stable for the whole frame.
module conv_stream_engine #(
   parameter int DATA_WIDTH  = 8,
   parameter int IFMAP_SIZE  = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int IN_CH       = 2,
   parameter int STRIDE      = 1,
   parameter int PADDING     = 1,
   parameter int ACC_WIDTH   = 24,
   parameter int OUT_SHIFT   = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   relu_en,
   input  logic [IN_CH-1:0][IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][DATA_WIDTH-1:0] ifmap,
   input  logic [IN_CH-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weights,
   input  logic signed [ACC_WIDTH-1:0] bias,
   conv_stream_engine_if.master    out_if,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             dbg_state
);
   localparam int OFMAP_SIZE = (IFMAP_SIZE + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
   localparam int COORD_W    = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;
   localparam int CH_W       = (IN_CH > 1) ? $clog2(IN_CH) : 1;
   localparam int PIX_IW     = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
   localparam int K_IW       = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int PROD_W     = 2*DATA_WIDTH + 1;

   localparam logic [CH_W-1:0]    LAST_CH = CH_W'(IN_CH - 1);
   localparam logic [COORD_W-1:0] LAST_RC = COORD_W'(OFMAP_SIZE - 1);

   // Clamp limits expressed at accumulator width.
   localparam logic signed [ACC_WIDTH-1:0] U_MAX =
      {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] S_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] S_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, DONE} state_t;

   state_t                      state, state_next;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] mac;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic [CH_W-1:0]             ch;
   logic [COORD_W-1:0]          row, col;
   logic                        relu_q;
   logic [DATA_WIDTH-1:0]       data_q;
   logic                        valid_q;
   logic                        hs;
   logic                        last_pix;

   // Shift, then clamp either to [0, 2^DW-1] (ReLU) or to the signed DW range.
   function automatic logic [DATA_WIDTH-1:0] clamp_pix(input logic signed [ACC_WIDTH-1:0] a,
                                                       input logic relu);
      logic signed [ACC_WIDTH-1:0] s;
      s = a >>> OUT_SHIFT;
      clamp_pix = s[DATA_WIDTH-1:0];
      if (relu) begin
         if (s[ACC_WIDTH-1])  clamp_pix = '0;
         else if (s > U_MAX)  clamp_pix = '1;
      end else begin
         if (s < S_MIN)       clamp_pix = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         else if (s > S_MAX)  clamp_pix = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   endfunction

   assign hs       = valid_q && out_if.out_ready;
   assign last_pix = (row == LAST_RC) && (col == LAST_RC);
   assign acc_sum  = acc + mac;

   // Window MAC of channel ch at the current output position; padding reads as zero.
   always_comb begin
      mac = '0;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
         for (int j = 0; j < KERNEL_SIZE; j++) begin
            int                        tr, tc;
            logic signed [PROD_W-1:0]  pix_x, wgt_x, prod;
            logic [DATA_WIDTH-1:0]     w;
            tr    = int'(row) * STRIDE + i - PADDING;
            tc    = int'(col) * STRIDE + j - PADDING;
            w     = weights[ch][K_IW'(i)][K_IW'(j)];
            wgt_x = {{(DATA_WIDTH+1){w[DATA_WIDTH-1]}}, w};
            pix_x = '0;
            if (tr >= 0 && tr < IFMAP_SIZE && tc >= 0 && tc < IFMAP_SIZE)
               pix_x = {{(DATA_WIDTH+1){1'b0}}, ifmap[ch][PIX_IW'(tr)][PIX_IW'(tc)]};
            prod = pix_x * wgt_x;
            mac  = mac + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ACCUM;
         ACCUM:   if (ch == LAST_CH) state_next = OUTPUT;
         OUTPUT:  if (hs) state_next = last_pix ? DONE : ACCUM;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: accumulator, channel/pixel counters, latched mode and output pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         ch     <= '0;
         row    <= '0;
         col    <= '0;
         relu_q <= 1'b0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               acc    <= bias;
               ch     <= '0;
               row    <= '0;
               col    <= '0;
               relu_q <= relu_en;
            end
            ACCUM: begin
               acc <= acc_sum;
               ch  <= ch + 1'b1;
               if (ch == LAST_CH) data_q <= clamp_pix(acc_sum, relu_q);
            end
            OUTPUT: if (hs && !last_pix) begin
               acc <= bias;
               ch  <= '0;
               if (col == LAST_RC) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered status flags, derived from the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         valid_q <= (state_next == OUTPUT);
         busy    <= (state_next == ACCUM) || (state_next == OUTPUT);
         done    <= (state_next == DONE);
      end
   end

   assign out_if.out_valid = valid_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_row   = row;
   assign out_if.out_col   = col;
   assign dbg_state        = state;
endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: a STRIDE=1 and a STRIDE=2 instance share the input
// maps; expected pixels come from a plain integer convolution model.
module tb_conv_stream_engine;
   localparam int DW    = 8;
   localparam int IFS   = 8;
   localparam int K     = 3;
   localparam int IN_CH = 2;
   localparam int PAD   = 1;
   localparam int ACC   = 24;
   localparam int SH    = 0;

   logic clk, reset_n, start_a, start_b, relu_en;
   logic [IN_CH-1:0][IFS-1:0][IFS-1:0][DW-1:0] ifmap;
   logic [IN_CH-1:0][K-1:0][K-1:0][DW-1:0]     weights;
   logic [ACC-1:0] bias;
   logic busy_a, done_a, busy_b, done_b;
   logic [1:0] st_a, st_b;

   conv_stream_engine_if #(.DATA_WIDTH(DW), .COORD_W(3)) ifa ();
   conv_stream_engine_if #(.DATA_WIDTH(DW), .COORD_W(2)) ifb ();

   conv_stream_engine #(.DATA_WIDTH(DW), .IFMAP_SIZE(IFS), .KERNEL_SIZE(K), .IN_CH(IN_CH),
      .STRIDE(1), .PADDING(PAD), .ACC_WIDTH(ACC), .OUT_SHIFT(SH)) u_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .relu_en(relu_en), .ifmap(ifmap),
      .weights(weights), .bias(bias), .out_if(ifa), .busy(busy_a), .done(done_a),
      .dbg_state(st_a));

   conv_stream_engine #(.DATA_WIDTH(DW), .IFMAP_SIZE(IFS), .KERNEL_SIZE(K), .IN_CH(IN_CH),
      .STRIDE(2), .PADDING(PAD), .ACC_WIDTH(ACC), .OUT_SHIFT(SH)) u_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .relu_en(relu_en), .ifmap(ifmap),
      .weights(weights), .bias(bias), .out_if(ifb), .busy(busy_b), .done(done_b),
      .dbg_state(st_b));

   // Reference data and scoreboard state.
   int ifm_m [IN_CH][IFS][IFS];
   int wgt_m [IN_CH][K][K];
   int b_m;
   bit relu_m;
   logic [31:0] exp_q_a[$];
   logic [31:0] exp_q_b[$];
   int n_checks = 0;
   int n_pass   = 0;
   int hold_low = 0;
   bit rand_ready = 0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic int model_pix(input int stride, input int r, input int c);
      int sum, tr, tc;
      sum = b_m;
      for (int ch = 0; ch < IN_CH; ch++)
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
               tr = r * stride + i - PAD;
               tc = c * stride + j - PAD;
               if (tr >= 0 && tr < IFS && tc >= 0 && tc < IFS)
                  sum += ifm_m[ch][tr][tc] * wgt_m[ch][i][j];
            end
      sum = sum >>> SH;
      if (relu_m) begin
         if (sum < 0) sum = 0;
         else if (sum > 255) sum = 255;
      end else begin
         if (sum < -128) sum = -128;
         else if (sum > 127) sum = 127;
      end
      return sum & 255;
   endfunction

   task automatic fill_expected(input int which);
      int stride, of;
      logic [31:0] w;
      stride = (which == 0) ? 1 : 2;
      of = (IFS + 2*PAD - K) / stride + 1;
      for (int r = 0; r < of; r++)
         for (int c = 0; c < of; c++) begin
            w = 32'((r << 16) | (c << 8) | model_pix(stride, r, c));
            if (which == 0) exp_q_a.push_back(w);
            else            exp_q_b.push_back(w);
         end
   endtask

   // ---------------- driver tasks ----------------
   // mode 0: all ones; 1: 255/127; 2: 255/-128; 3: full random; 4: small random
   task automatic load(input int mode, input int bval, input bit relu);
      for (int c = 0; c < IN_CH; c++) begin
         for (int r = 0; r < IFS; r++)
            for (int k = 0; k < IFS; k++) begin
               case (mode)
                  0:       ifm_m[c][r][k] = 1;
                  1, 2:    ifm_m[c][r][k] = 255;
                  3:       ifm_m[c][r][k] = int'($urandom_range(0, 255));
                  default: ifm_m[c][r][k] = int'($urandom_range(0, 15));
               endcase
               ifmap[c][r][k] = DW'(ifm_m[c][r][k]);
            end
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
               case (mode)
                  0:       wgt_m[c][i][j] = 1;
                  1:       wgt_m[c][i][j] = 127;
                  2:       wgt_m[c][i][j] = -128;
                  3:       wgt_m[c][i][j] = int'($urandom_range(0, 255)) - 128;
                  default: wgt_m[c][i][j] = int'($urandom_range(0, 15)) - 8;
               endcase
               weights[c][i][j] = DW'(wgt_m[c][i][j]);
            end
      end
      b_m     = bval;
      bias    = ACC'(b_m);
      relu_m  = relu;
      relu_en = relu;
   endtask

   task automatic set_start(input int which, input logic v);
      if (which == 0) start_a = v;
      else            start_b = v;
   endtask

   function automatic logic busy_of(input int w);
      return (w == 0) ? busy_a : busy_b;
   endfunction

   function automatic logic done_of(input int w);
      return (w == 0) ? done_a : done_b;
   endfunction

   function automatic logic [1:0] state_of(input int w);
      return (w == 0) ? st_a : st_b;
   endfunction

   task automatic frame(input int which, input int stall, input int glitch_at, input int exp_cycles);
      int cycles, busy_low, qsize;
      fill_expected(which);
      hold_low = stall;
      @(posedge clk); #1;
      set_start(which, 1'b1);
      @(posedge clk); #1;
      set_start(which, 1'b0);
      cycles   = 0;
      busy_low = 0;
      while (cycles < 3000) begin
         @(posedge clk); #1;
         cycles++;
         set_start(which, cycles == glitch_at);
         if (done_of(which)) break;
         if (!busy_of(which)) busy_low++;
      end
      qsize = (which == 0) ? exp_q_a.size() : exp_q_b.size();
      check("done_seen", done_of(which), 1);
      if (exp_cycles >= 0) check("frame_cycles", cycles, exp_cycles);
      check("busy_held", busy_low, 0);
      check("busy_at_done", busy_of(which), 0);
      check("queue_drained", qsize, 0);
      set_start(which, 1'b1);  // lands in the DONE cycle
      @(posedge clk); #1;
      set_start(which, 1'b0);
      check("done_width", done_of(which), 0);
      check("idle_after_done", state_of(which), 0);
      check("no_restart_busy", busy_of(which), 0);
   endtask

   task automatic abort_test();
      bit found;
      fill_expected(0);
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 1000 && !found; n++) begin
         @(posedge clk); #1;
         found = (ifa.out_row == 3'd2) && (ifa.out_col == 3'd5) && (st_a == 2'd1);
      end
      check("reach_pixel_2_5", found, 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_valid", ifa.out_valid, 0);
      check("abort_busy", busy_a, 0);
      check("abort_done", done_a, 0);
      check("abort_state", st_a, 0);
      exp_q_a.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // out_ready driver for instance A: forced-low stall, random, or always high.
   initial begin
      ifa.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (hold_low > 0) begin
            ifa.out_ready = 1'b0;
            if (ifa.out_valid) hold_low--;
         end else if (rand_ready) begin
            ifa.out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            ifa.out_ready = 1'b1;
         end
      end
   end

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      logic [31:0] w;
      if (reset_n && ifa.out_valid) begin
         w = (32'(ifa.out_row) << 16) | (32'(ifa.out_col) << 8) | 32'(ifa.out_data);
         if (exp_q_a.size() == 0) check("extra_pixel_a", w, 32'hFFFF_FFFF);
         else if (ifa.out_ready) check("pixel_a", w, exp_q_a.pop_front());
         else check("stall_hold_a", w, exp_q_a[0]);
      end
   end

   always @(negedge clk) begin
      logic [31:0] w;
      if (reset_n && ifb.out_valid) begin
         w = (32'(ifb.out_row) << 16) | (32'(ifb.out_col) << 8) | 32'(ifb.out_data);
         if (exp_q_b.size() == 0) check("extra_pixel_b", w, 32'hFFFF_FFFF);
         else if (ifb.out_ready) check("pixel_b", w, exp_q_b.pop_front());
         else check("stall_hold_b", w, exp_q_b[0]);
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      start_a       = 1'b0;
      start_b       = 1'b0;
      ifb.out_ready = 1'b1;
      load(0, 0, 1'b1);
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", ifa.out_valid, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_data", ifa.out_data, 0);
      check("rst_row", ifa.out_row, 0);
      check("rst_col", ifa.out_col, 0);
      check("rst_state", st_a, 0);
      reset_n = 1'b1;

      frame(0, 0, 50, 192);          // all ones, start pulsed mid-frame
      frame(0, 5, -1, 197);          // 5-cycle stall on pixel (0,0)
      load(0, -20, 1'b1); frame(0, 0, -1, 192);
      load(0, -20, 1'b0); frame(0, 0, -1, 192);
      load(1, 0, 1'b1);   frame(0, 0, -1, 192);
      load(1, 0, 1'b0);   frame(0, 0, -1, 192);
      load(2, 0, 1'b0);   frame(0, 0, -1, 192);
      load(0, 0, 1'b1);
      abort_test();
      frame(0, 0, -1, 192);
      frame(1, 0, -1, 48);           // stride 2

      rand_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         load(3 + (t % 2), int'($urandom_range(0, 400)) - 200, 1'($urandom_range(0, 1)));
         frame(0, 0, -1, -1);
         frame(1, 0, -1, 48);
      end
      rand_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Multi-channel 2-D convolution engine that generalises the single-channel conv block.
- Accumulates a KERNEL_SIZE x KERNEL_SIZE window over IN_CH input channels, adds a signed bias, then applies an arithmetic right shift and optional ReLU with saturation.
- Emits one output pixel at a time on a valid/ready stream instead of writing a combinational output array.
- Sits between the ifmap buffer and the pooling stage in the CNN datapath.

Parameters:
- DATA_WIDTH, 8, pixel and output width.
- IFMAP_SIZE, 8, input feature map height and width.
- KERNEL_SIZE, 3, kernel height and width.
- IN_CH, 2, number of input channels accumulated per output pixel.
- STRIDE, 1, window step; legal values are 1 and 2.
- PADDING, 1, zero-padding on each border.
- ACC_WIDTH, 24, signed accumulator width.
- OUT_SHIFT, 0, arithmetic right shift applied before clamping.
- OFMAP_SIZE, derived as (IFMAP_SIZE+2*PADDING-KERNEL_SIZE)/STRIDE+1, output map size.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- relu_en  in  1  selects the output mode; sampled when start is accepted.
- ifmap  in  [IN_CH][IFMAP_SIZE][IFMAP_SIZE] x DATA_WIDTH  unsigned input pixels.
- weights  in  [IN_CH][KERNEL_SIZE][KERNEL_SIZE] x DATA_WIDTH  signed weights.
- bias  in  ACC_WIDTH  signed bias.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  output pixel.
- out_row  out  clog2(OFMAP_SIZE)  row of the current output pixel.
- out_col  out  clog2(OFMAP_SIZE)  column of the current output pixel.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE; out_valid, out_data, out_row, out_col, busy and done are 0; accumulator, channel counter and pixel counters are 0.
- Reset asserted mid-frame aborts the frame immediately; no partial output follows.
- Input stability: ifmap, weights and bias must be held stable from start acceptance until done. The block does not register them.

FSM states: IDLE, ACCUM, OUTPUT, DONE.
- IDLE: start=1 moves to ACCUM. On that edge: row=col=ch=0, acc<=sign-extended bias, relu mode latched, busy<=1.
- ACCUM: one channel per cycle, acc <= acc + MAC(window of channel ch).
  - ch increments each cycle.
  - At ch==IN_CH-1, the final sum is clamped into out_data and the FSM moves to OUTPUT.
- OUTPUT: out_valid=1. out_data, out_row and out_col stay stable until out_valid&&out_ready.
  - On the handshake, if (row,col)==(OFMAP_SIZE-1,OFMAP_SIZE-1), go to DONE.
  - Otherwise advance col (wrap to 0 and increment row), set acc<=bias and ch<=0, and return to ACCUM.
  - out_valid drops in the cycle after the handshake.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Start arriving in the DONE cycle is ignored.
- start while busy is ignored.

Window addressing:
- tr = row*STRIDE + i - PADDING and tc = col*STRIDE + j - PADDING, computed as signed integers.
- Out-of-range positions (tr or tc <0 or >=IFMAP_SIZE) contribute zero.

Arithmetic:
- Each pixel is zero-extended to DATA_WIDTH+1 bits and treated as signed. Each product is sign-extended to ACC_WIDTH before summing.
- s = acc >>> OUT_SHIFT.
- relu_en=1: output is 0 if s<0, 2^DATA_WIDTH-1 if s exceeds that, else s.
- relu_en=0: s saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and is output as two's complement.

Timing:
- Per-pixel latency is IN_CH ACCUM cycles plus at least 1 OUTPUT cycle.
- With out_ready tied high, a frame takes OFMAP_SIZE^2*(IN_CH+1) cycles from start acceptance to the done pulse.

Test Plan:
- Defaults, ifmap all 1, weights all 1, bias 0, relu_en=1, out_ready=1 -> 64 pixels in raster order: (0,0)=8, (0,3)=12, (3,3)=18, (7,7)=8; done pulses 192 cycles after start; busy high throughout.
- Same stimulus, out_ready low for 5 cycles when pixel (0,0) is presented -> out_valid held 5 cycles with out_data=8 and row/col=0 stable; no pixel dropped or duplicated; total cycles 197.
- bias=-20 on all-ones stimulus -> relu_en=1 gives interior pixels 0; relu_en=0 gives interior 0xFE and corners (-12) 0xF4.
- ifmap all 255, weights all 127, bias 0 -> relu_en=1 gives interior 255 (sum 582930, saturated); relu_en=0 gives 127. Weights all -128 with relu_en=0 -> -128 (0x80).
- reset_n low during ACCUM of pixel (2,5) -> out_valid, busy and done are 0 asynchronously; start after release produces the full frame from (0,0) with correct values. start pulsed while busy -> no restart.
- STRIDE=2, all-ones stimulus -> OFMAP_SIZE=4, 16 pixels: (0,0)=8, (1,1)=18, (3,3)=18; done pulses after 48 cycles.
